// File: rtl/path_delay_monitor_if.sv
// Result channel of the path delay monitor: one measured path per
// valid/ready handshake. The monitor drives the master side, the consumer
// of measurement results sits on the slave side.
interface path_delay_monitor_if #(
  parameter int CNT_W = 8,
  parameter int SRC_W = 2
);
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_delay;
  logic [SRC_W-1:0] res_src;
  logic [1:0]       res_status;

  modport master (
    output res_valid,
    output res_delay,
    output res_src,
    output res_status,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_delay,
    input  res_src,
    input  res_status,
    output res_ready
  );
endinterface

// File: rtl/path_delay_monitor.sv
// Path delay monitor: measures the cycle delay from a transition on any
// source net to the following transition on the destination net and grades
// it against an expected delay and a +/- tolerance captured at launch.
// Results leave through a valid/ready register; error flags are sticky.
module path_delay_monitor #(
  parameter int N_SRC   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int SRC_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      src,
  input  logic                  dst,
  input  logic [CNT_W-1:0]      exp_delay,
  input  logic [CNT_W-1:0]      tol,
  path_delay_monitor_if.master  res,
  output logic                  err_overlap,
  output logic                  err_spurious,
  output logic                  err_drop
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [1:0] ST_MATCH   = 2'b00;
  localparam logic [1:0] ST_EARLY   = 2'b01;
  localparam logic [1:0] ST_LATE    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_e;

  // Grade a delay in one extra bit so that delay+tol and exp+tol never wrap.
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] d,
                                          input logic [CNT_W-1:0] e,
                                          input logic [CNT_W-1:0] t);
    logic [CNT_W:0] d_x;
    logic [CNT_W:0] e_x;
    logic [CNT_W:0] t_x;
    d_x = {1'b0, d};
    e_x = {1'b0, e};
    t_x = {1'b0, t};
    if ((d_x + t_x) < e_x) begin
      classify = ST_EARLY;
    end else if (d_x > (e_x + t_x)) begin
      classify = ST_LATE;
    end else begin
      classify = ST_MATCH;
    end
  endfunction

  // Index of the lowest set bit; callers only use it on a non-zero vector.
  function automatic logic [SRC_W-1:0] lowest_idx(input logic [N_SRC-1:0] v);
    lowest_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_idx = SRC_W'(i);
      end
    end
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             primed_q, primed_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic             dst_q, dst_d;
  logic [SRC_W-1:0] lat_src_q, lat_src_d;
  logic [CNT_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] tol_q, tol_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_delay_q, res_delay_d;
  logic [SRC_W-1:0] res_src_q, res_src_d;
  logic [1:0]       res_status_q, res_status_d;
  logic             err_overlap_q, err_overlap_d;
  logic             err_spurious_q, err_spurious_d;
  logic             err_drop_q, err_drop_d;

  logic [N_SRC-1:0] src_edge_s;
  logic             dst_edge_s;
  logic             done_s;
  logic [CNT_W-1:0] done_delay_s;
  logic [SRC_W-1:0] done_src_s;
  logic [1:0]       done_status_s;

  // Edge detection, launch/measure FSM and result register next-state.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    primed_d       = 1'b1;
    src_d          = src;
    dst_d          = dst;
    lat_src_d      = lat_src_q;
    exp_d          = exp_q;
    tol_d          = tol_q;
    res_valid_d    = res_valid_q;
    res_delay_d    = res_delay_q;
    res_src_d      = res_src_q;
    res_status_d   = res_status_q;
    err_overlap_d  = err_overlap_q;
    err_spurious_d = err_spurious_q;
    err_drop_d     = err_drop_q;
    done_s         = 1'b0;
    done_delay_s   = '0;
    done_src_s     = lat_src_q;
    done_status_s  = ST_MATCH;

    // The first cycle after reset only loads the history registers.
    if (primed_q) begin
      src_edge_s = src ^ src_q;
      dst_edge_s = dst ^ dst_q;
    end else begin
      src_edge_s = '0;
      dst_edge_s = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (src_edge_s != '0) begin
          lat_src_d = lowest_idx(src_edge_s);
          exp_d     = exp_delay;
          tol_d     = tol;
          if (dst_edge_s) begin
            done_s        = 1'b1;
            done_delay_s  = '0;
            done_src_s    = lowest_idx(src_edge_s);
            done_status_s = classify('0, exp_delay, tol);
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = S_ARMED;
          end
        end else if (dst_edge_s) begin
          err_spurious_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_ARMED: begin
        // A relaunch attempt is flagged but never disturbs the running count.
        if (src_edge_s != '0) begin
          err_overlap_d = 1'b1;
        end else begin
          err_overlap_d = err_overlap_q;
        end
        if (dst_edge_s) begin
          done_s        = 1'b1;
          done_delay_s  = cnt_q;
          done_status_s = classify(cnt_q, exp_q, tol_q);
          cnt_d         = '0;
          state_d       = S_IDLE;
        end else if (cnt_q == TIMEOUT_C) begin
          done_s        = 1'b1;
          done_delay_s  = TIMEOUT_C;
          done_status_s = ST_TIMEOUT;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A completion overwrites the held result only if it is free or leaving now.
    if (done_s) begin
      if (!res_valid_q || res.res_ready) begin
        res_valid_d  = 1'b1;
        res_delay_d  = done_delay_s;
        res_src_d    = done_src_s;
        res_status_d = done_status_s;
      end else begin
        err_drop_d = 1'b1;
      end
    end else if (res_valid_q && res.res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // State, history and result registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      primed_q       <= 1'b0;
      src_q          <= '0;
      dst_q          <= 1'b0;
      lat_src_q      <= '0;
      exp_q          <= '0;
      tol_q          <= '0;
      res_valid_q    <= 1'b0;
      res_delay_q    <= '0;
      res_src_q      <= '0;
      res_status_q   <= ST_MATCH;
      err_overlap_q  <= 1'b0;
      err_spurious_q <= 1'b0;
      err_drop_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      primed_q       <= primed_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      lat_src_q      <= lat_src_d;
      exp_q          <= exp_d;
      tol_q          <= tol_d;
      res_valid_q    <= res_valid_d;
      res_delay_q    <= res_delay_d;
      res_src_q      <= res_src_d;
      res_status_q   <= res_status_d;
      err_overlap_q  <= err_overlap_d;
      err_spurious_q <= err_spurious_d;
      err_drop_q     <= err_drop_d;
    end
  end

  assign res.res_valid  = res_valid_q;
  assign res.res_delay  = res_delay_q;
  assign res.res_src    = res_src_q;
  assign res.res_status = res_status_q;
  assign err_overlap    = err_overlap_q;
  assign err_spurious   = err_spurious_q;
  assign err_drop       = err_drop_q;

endmodule
